// File: rtl/io_port_unit.sv
// Buffered I/O port: a DEPTH-entry output FIFO drained over valid/ready, and a
// one-entry input holding register filled over valid/ready and read by the datapath.
module io_port_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     OutputWrite,
    input  logic [WIDTH-1:0]         OutData,
    input  logic                     InRead,
    output logic [WIDTH-1:0]         InData,
    output logic                     InEmpty,
    input  logic                     ClearFlags,
    output logic [WIDTH-1:0]         ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    input  logic [WIDTH-1:0]         ext_in_data,
    input  logic                     ext_in_valid,
    output logic                     ext_in_ready,
    output logic [$clog2(DEPTH):0]   OutCount,
    output logic                     Overflow,
    output logic                     Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               wr_ptr;
    logic [CW-1:0]               count;

    logic full;
    logic pop;
    logic push;
    logic push_drop;

    assign full      = (count == FULL_CNT);
    assign pop       = ext_out_valid && ext_out_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
    assign push      = OutputWrite && (!full || pop);
    assign push_drop = OutputWrite && full && !pop;

    assign ext_out_valid = (count != '0);
    assign ext_out_data  = mem[rd_ptr];
    assign OutCount      = count;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mem <= '0;
        end else if (push) begin
            mem[wr_ptr] <= OutData;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    logic [WIDTH-1:0] hold;
    logic             hold_empty;
    logic             cap;
    logic             read_empty;

    // Ready looks through a same-cycle read so capture and read can stream back to back.
    assign ext_in_ready = hold_empty || InRead;
    assign cap          = ext_in_valid && ext_in_ready;
    assign read_empty   = InRead && hold_empty;
    assign InData       = hold;
    assign InEmpty      = hold_empty;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            hold       <= '0;
            hold_empty <= 1'b1;
        end else begin
            if (cap) begin
                hold       <= ext_in_data;
                hold_empty <= 1'b0;
            end else if (InRead) begin
                hold_empty <= 1'b1;
            end
        end
    end

    // Sticky flags: a new error in the same cycle as ClearFlags keeps the flag set.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_drop)       Overflow <= 1'b1;
            else if (ClearFlags) Overflow <= 1'b0;
            if (read_empty)      Underflow <= 1'b1;
            else if (ClearFlags) Underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: directed scenarios plus a randomized run
// against a queue-based reference model of the FIFO, holding register and flags.
module tb_io_port_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             OutputWrite;
    logic [WIDTH-1:0] OutData;
    logic             InRead;
    logic [WIDTH-1:0] InData;
    logic             InEmpty;
    logic             ClearFlags;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic [2:0]       OutCount;
    logic             Overflow;
    logic             Underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_hold;
    bit               m_empty;
    bit               m_ovf;
    bit               m_unf;

    io_port_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .OutputWrite(OutputWrite), .OutData(OutData),
        .InRead(InRead), .InData(InData), .InEmpty(InEmpty), .ClearFlags(ClearFlags),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .OutCount(OutCount), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        OutputWrite = 0; OutData = '0; InRead = 0; ClearFlags = 0;
        ext_out_ready = 0; ext_in_data = '0; ext_in_valid = 0;
    endtask

    task automatic model_reset();
        mq.delete(); m_hold = '0; m_empty = 1; m_ovf = 0; m_unf = 0;
    endtask

    // advance the model by one clock edge from the currently driven inputs
    task automatic model_update();
        bit pop, push, cap, so, su;
        pop  = (mq.size() > 0) && ext_out_ready;
        push = OutputWrite && (mq.size() < DEPTH || pop);
        so   = OutputWrite && !push;
        if (pop)  mq.delete(0);
        if (push) mq.push_back(OutData);
        cap = ext_in_valid && (m_empty || InRead);
        su  = InRead && m_empty;
        if (cap) begin m_hold = ext_in_data; m_empty = 0; end
        else if (InRead) m_empty = 1;
        m_ovf = so || (m_ovf && !ClearFlags);
        m_unf = su || (m_unf && !ClearFlags);
    endtask

    // inputs are driven and outputs sampled around the falling edge
    task automatic cycle();
        if (Reset) model_update();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 0;
        for (int i = 0; i < 5; i++) begin
            OutputWrite = 1'($urandom); OutData = 16'($urandom); InRead = 1'($urandom);
            ClearFlags = 1'($urandom); ext_out_ready = 1'($urandom);
            ext_in_data = 16'($urandom); ext_in_valid = 1'($urandom);
            cycle();
        end
        model_reset();
        idle();
        Reset = 1;
        cycle();
        checks++; if (OutCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", OutCount); end
        checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ext_out_valid); end
        checks++; if (ext_out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0000", ext_out_data); end
        checks++; if (InEmpty !== 1'b1) begin errors++; $display("FAIL reset_inempty got %b exp 1", InEmpty); end
        checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ext_in_ready); end
        checks++; if (InData !== 16'h0) begin errors++; $display("FAIL reset_indata got %h exp 0000", InData); end
        checks++; if ({Overflow, Underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {Overflow, Underflow}); end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] w[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        idle();
        for (int i = 0; i < 4; i++) begin
            OutputWrite = 1; OutData = w[i];
            cycle();
        end
        checks++; if (OutCount !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", OutCount); end
        OutData = 16'h5555;
        cycle();
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", Overflow); end
        checks++; if (OutCount !== 3'd4) begin errors++; $display("FAIL fill_drop_count got %0d exp 4", OutCount); end
        OutputWrite = 0; ext_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ext_out_valid !== 1'b1 || ext_out_data !== w[i]) begin
                errors++; $display("FAIL drain_word%0d got v=%b %h exp v=1 %h", i, ext_out_valid, ext_out_data, w[i]);
            end
            cycle();
        end
        checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_end got %b exp 0", ext_out_valid); end
        idle();
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] w[4] = '{16'h0202, 16'h0303, 16'h0404, 16'hAAAA};
        idle();
        ClearFlags = 1;
        cycle();
        ClearFlags = 0;
        for (int i = 1; i <= 4; i++) begin
            OutputWrite = 1; OutData = 16'(i * 16'h0101);
            cycle();
        end
        OutData = 16'hAAAA; ext_out_ready = 1;
        cycle();
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got %b exp 0", Overflow); end
        checks++; if (OutCount !== 3'd4) begin errors++; $display("FAIL fullpp_count got %0d exp 4", OutCount); end
        OutputWrite = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ext_out_data !== w[i]) begin
                errors++; $display("FAIL fullpp_word%0d got %h exp %h", i, ext_out_data, w[i]);
            end
            cycle();
        end
        checks++; if (OutCount !== 3'd0) begin errors++; $display("FAIL fullpp_empty got %0d exp 0", OutCount); end
        idle();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] prev;
        bit               prev_stall;
        idle();
        for (int i = 0; i < 4; i++) begin
            OutputWrite = 1; OutData = 16'($urandom);
            cycle();
        end
        prev_stall = 0; prev = '0;
        for (int i = 0; i < 20; i++) begin
            OutputWrite = 1'($urandom); OutData = 16'($urandom);
            ext_out_ready = 1'($urandom);
            if (prev_stall) begin
                checks++;
                if (ext_out_data !== prev) begin errors++; $display("FAIL bp_stable cyc%0d got %h exp %h", i, ext_out_data, prev); end
            end
            if (mq.size() > 0) begin
                checks++;
                if (ext_out_data !== mq[0]) begin errors++; $display("FAIL bp_head cyc%0d got %h exp %h", i, ext_out_data, mq[0]); end
            end
            prev_stall = ext_out_valid && !ext_out_ready;
            prev = ext_out_data;
            cycle();
        end
        OutputWrite = 0; ext_out_ready = 1;
        while (mq.size() > 0) begin
            checks++;
            if (ext_out_data !== mq[0]) begin errors++; $display("FAIL bp_tail got %h exp %h", ext_out_data, mq[0]); end
            cycle();
        end
        checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b exp 0", ext_out_valid); end
        idle();
    endtask

    task automatic test_input_path();
        idle();
        ext_in_valid = 1; ext_in_data = 16'h00C3;
        cycle();
        checks++; if (InData !== 16'h00C3 || InEmpty !== 1'b0) begin errors++; $display("FAIL in_capture got %h e=%b exp 00c3 e=0", InData, InEmpty); end
        checks++; if (ext_in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_full got %b exp 0", ext_in_ready); end
        ext_in_data = 16'h0042;
        cycle();
        checks++; if (InData !== 16'h00C3) begin errors++; $display("FAIL in_holdoff got %h exp 00c3", InData); end
        InRead = 1;
        #1;
        checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_read got %b exp 1", ext_in_ready); end
        cycle();
        checks++; if (InData !== 16'h0042 || InEmpty !== 1'b0) begin errors++; $display("FAIL in_stream got %h e=%b exp 0042 e=0", InData, InEmpty); end
        ext_in_valid = 0;
        cycle();
        checks++; if (InEmpty !== 1'b1 || InData !== 16'h0042) begin errors++; $display("FAIL in_read_empty got %h e=%b exp 0042 e=1", InData, InEmpty); end
        idle();
    endtask

    task automatic test_underflow_clear();
        idle();
        InRead = 1;
        cycle();
        checks++; if (Underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b exp 1", Underflow); end
        checks++; if (InData !== 16'h0042 || InEmpty !== 1'b1) begin errors++; $display("FAIL unf_stale got %h e=%b exp 0042 e=1", InData, InEmpty); end
        ClearFlags = 1;
        cycle();
        checks++; if (Underflow !== 1'b1) begin errors++; $display("FAIL unf_set_wins got %b exp 1", Underflow); end
        InRead = 0;
        cycle();
        checks++; if (Underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", Underflow); end
        idle();
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            OutputWrite   = ($urandom_range(0, 3) != 0);
            OutData       = 16'($urandom);
            ext_out_ready = ($urandom_range(0, 2) == 0);
            InRead        = 1'($urandom);
            ext_in_valid  = 1'($urandom);
            ext_in_data   = 16'($urandom);
            ClearFlags    = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (ext_in_ready !== (m_empty || InRead)) begin
                errors++; $display("FAIL rnd_in_ready cyc%0d got %b exp %b", i, ext_in_ready, m_empty || InRead);
            end
            cycle();
            checks++;
            if (int'(OutCount) != mq.size() || ext_out_valid !== (mq.size() > 0)) begin
                errors++; $display("FAIL rnd_count cyc%0d got %0d v=%b exp %0d", i, OutCount, ext_out_valid, mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (ext_out_data !== mq[0]) begin errors++; $display("FAIL rnd_head cyc%0d got %h exp %h", i, ext_out_data, mq[0]); end
            end
            checks++;
            if (InData !== m_hold || InEmpty !== m_empty) begin
                errors++; $display("FAIL rnd_input cyc%0d got %h e=%b exp %h e=%b", i, InData, InEmpty, m_hold, m_empty);
            end
            checks++;
            if (Overflow !== m_ovf || Underflow !== m_unf) begin
                errors++; $display("FAIL rnd_flags cyc%0d got %b%b exp %b%b", i, Overflow, Underflow, m_ovf, m_unf);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        OutputWrite = 1; OutData = 16'hBEEF; ext_in_valid = 1; ext_in_data = 16'h1234;
        cycle();
        cycle();
        #2;
        Reset = 0;
        #1;
        checks++;
        if (OutCount !== 3'd0 || ext_out_valid !== 1'b0 || InEmpty !== 1'b1 || InData !== 16'h0) begin
            errors++; $display("FAIL async_reset got cnt=%0d v=%b e=%b d=%h exp 0 0 1 0000", OutCount, ext_out_valid, InEmpty, InData);
        end
        @(negedge CLK);
        model_reset();
        idle();
        Reset = 1;
        cycle();
        checks++; if (OutCount !== 3'd0) begin errors++; $display("FAIL async_reset_release got %0d exp 0", OutCount); end
    endtask

    initial begin
        idle();
        model_reset();
        Reset = 0;
        @(negedge CLK);
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_backpressure();
        test_input_path();
        test_underflow_clear();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
